// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
// Holds the fetch PC and issues single-outstanding word reads over a
// request/ready bus. Redirects come from ID (BrTaken) and from the control
// unit (Flush). The IF/ID triple IFPC/IFInsn/IFEn is registered.
// Optional feature: define IF_SKID_BUF_EN to add a one-entry skid buffer that
// captures a word arriving during Stall instead of discarding it.
module if_stage #(
    parameter int WORD_ADDR_W = 30,
    parameter int DATA_W      = 32,
    parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = {WORD_ADDR_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic [WORD_ADDR_W-1:0] NewPC,
    input  logic                   BrTaken,
    input  logic [WORD_ADDR_W-1:0] BrAddr,
    output logic                   BusReq,
    output logic [WORD_ADDR_W-1:0] BusAddr,
    input  logic                   BusRdy,
    input  logic [DATA_W-1:0]      BusRdData,
    output logic [WORD_ADDR_W-1:0] IFPC,
    output logic [DATA_W-1:0]      IFInsn,
    output logic                   IFEn,
    output logic                   Busy
);

`ifdef IF_SKID_BUF_EN
    typedef enum logic [1:0] {FETCH = 2'd0, DROP = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, DROP = 2'd1} state_t;
`endif

    localparam logic [WORD_ADDR_W-1:0] PC_ONE = {{(WORD_ADDR_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [WORD_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [WORD_ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [DATA_W-1:0]      if_insn_q, if_insn_d;
    logic                   if_en_q, if_en_d;
`ifdef IF_SKID_BUF_EN
    logic [WORD_ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0]      skid_insn_q, skid_insn_d;
    logic                   skid_vld_q, skid_vld_d;
`endif

    logic                   redirect;
    logic [WORD_ADDR_W-1:0] redirect_pc;
    logic                   bus_active;

    // Redirect resolution: Flush outranks BrTaken, and BrTaken is ignored under Stall.
    always_comb begin
        redirect    = Flush | (BrTaken & ~Stall);
        redirect_pc = Flush ? NewPC : BrAddr;
    end

    // Bus-facing outputs; the request is withdrawn asynchronously while reset is high.
    always_comb begin
`ifdef IF_SKID_BUF_EN
        bus_active = (state_q != HOLD);
`else
        bus_active = 1'b1;
`endif
        BusReq  = bus_active & ~reset;
        BusAddr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
        Busy    = (BusReq & ~BusRdy) | ((state_q == DROP) & ~reset);
        IFPC    = if_pc_q;
        IFInsn  = if_insn_q;
        IFEn    = if_en_q;
    end

    // Next-state logic for the fetch FSM, fetch PC and IF/ID register.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        if_pc_d     = if_pc_q;
        if_insn_d   = if_insn_q;
        if_en_d     = if_en_q;
`ifdef IF_SKID_BUF_EN
        skid_pc_d   = skid_pc_q;
        skid_insn_d = skid_insn_q;
        skid_vld_d  = skid_vld_q;
`endif
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    // In-flight word belongs to the old path; if it has not
                    // returned yet it must still be drained at its address.
                    if_en_d    = 1'b0;
                    fetch_pc_d = redirect_pc;
                    if (!BusRdy) begin
                        state_d     = DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end else if (Stall) begin
`ifdef IF_SKID_BUF_EN
                    if (BusRdy) begin
                        skid_pc_d   = fetch_pc_q;
                        skid_insn_d = BusRdData;
                        skid_vld_d  = 1'b1;
                        fetch_pc_d  = fetch_pc_q + PC_ONE;
                        state_d     = HOLD;
                    end
`endif
                end else if (BusRdy) begin
                    if_pc_d    = fetch_pc_q;
                    if_insn_d  = BusRdData;
                    if_en_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_ONE;
                end else begin
                    if_en_d = 1'b0;
                end
            end
            DROP: begin
                if (redirect) begin
                    if_en_d    = 1'b0;
                    fetch_pc_d = redirect_pc;
                end else if (!Stall) begin
                    if_en_d = 1'b0;
                end
                if (BusRdy) begin
                    state_d = FETCH;
                end
            end
`ifdef IF_SKID_BUF_EN
            HOLD: begin
                if (redirect) begin
                    skid_vld_d = 1'b0;
                    if_en_d    = 1'b0;
                    fetch_pc_d = redirect_pc;
                    state_d    = FETCH;
                end else if (!Stall) begin
                    if_pc_d    = skid_pc_q;
                    if_insn_d  = skid_insn_q;
                    if_en_d    = skid_vld_q;
                    skid_vld_d = 1'b0;
                    state_d    = FETCH;
                end
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_VECTOR;
            drop_addr_q <= {WORD_ADDR_W{1'b0}};
            if_pc_q     <= {WORD_ADDR_W{1'b0}};
            if_insn_q   <= {DATA_W{1'b0}};
            if_en_q     <= 1'b0;
`ifdef IF_SKID_BUF_EN
            skid_pc_q   <= {WORD_ADDR_W{1'b0}};
            skid_insn_q <= {DATA_W{1'b0}};
            skid_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            if_pc_q     <= if_pc_d;
            if_insn_q   <= if_insn_d;
            if_en_q     <= if_en_d;
`ifdef IF_SKID_BUF_EN
            skid_pc_q   <= skid_pc_d;
            skid_insn_q <= skid_insn_d;
            skid_vld_q  <= skid_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage (RESET_VECTOR = 0x100).
// Each row drives inputs at the falling edge, checks the combinational bus
// outputs before the rising edge and the IF/ID register just after it.
module tb_if_stage;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          Stall, Flush, BrTaken, BusRdy;
    logic [AW-1:0] NewPC, BrAddr;
    logic [DW-1:0] BusRdData;
    logic          BusReq, IFEn, Busy;
    logic [AW-1:0] BusAddr, IFPC;
    logic [DW-1:0] IFInsn;

    int checks   = 0;
    int failures = 0;

    if_stage #(
        .WORD_ADDR_W  (AW),
        .DATA_W       (DW),
        .RESET_VECTOR (30'h100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .Flush     (Flush),
        .NewPC     (NewPC),
        .BrTaken   (BrTaken),
        .BrAddr    (BrAddr),
        .BusReq    (BusReq),
        .BusAddr   (BusAddr),
        .BusRdy    (BusRdy),
        .BusRdData (BusRdData),
        .IFPC      (IFPC),
        .IFInsn    (IFInsn),
        .IFEn      (IFEn),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st, fl;
        logic [AW-1:0] npc;
        logic          br;
        logic [AW-1:0] ba;
        logic          rdy;
        logic [DW-1:0] d;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_busy;
        logic          e_en;
        logic [AW-1:0] e_pc;
        logic [DW-1:0] e_insn;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic st, input logic fl, input logic [AW-1:0] npc,
                     input logic br, input logic [AW-1:0] ba, input logic rdy,
                     input logic [DW-1:0] d, input logic e_req, input logic [AW-1:0] e_addr,
                     input logic e_busy, input logic e_en, input logic [AW-1:0] e_pc,
                     input logic [DW-1:0] e_insn);
        vec_t r;
        r = '{st, fl, npc, br, ba, rdy, d, e_req, e_addr, e_busy, e_en, e_pc, e_insn};
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        //  st fl npc          br ba       rdy d             req addr          busy en pc            insn
        // reset release, BusRdy tied high
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0100, 1, 30'h100,      0, 1, 30'h100,      32'hD000_0100);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0101, 1, 30'h101,      0, 1, 30'h101,      32'hD000_0101);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0102, 1, 30'h102,      0, 1, 30'h102,      32'hD000_0102);
        // flush to 0x10 with data returning same cycle (discarded, stays FETCH)
        v(0, 1, 30'h10,      0, 30'h0,  1, 32'hDEAD_BEEF, 1, 30'h103,      0, 0, 30'h0,        32'h0);
        // three wait cycles at 0x10
        v(0, 0, 30'h0,       0, 30'h0,  0, 32'h0,         1, 30'h10,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  0, 32'h0,         1, 30'h10,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  0, 32'h0,         1, 30'h10,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0010, 1, 30'h10,       0, 1, 30'h10,       32'hD000_0010);
        // branch to 0x40 while 0x11 pending -> DROP
        v(0, 0, 30'h0,       0, 30'h0,  0, 32'h0,         1, 30'h11,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       1, 30'h40, 0, 32'h0,         1, 30'h11,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  0, 32'h0,         1, 30'h11,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0011, 1, 30'h11,       1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0040, 1, 30'h40,       0, 1, 30'h40,       32'hD000_0040);
        // flush and branch together: flush target wins
        v(0, 1, 30'h8,       1, 30'h40, 1, 32'h1234_5678, 1, 30'h41,       0, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0008, 1, 30'h8,        0, 1, 30'h8,        32'hD000_0008);
        // flush under stall is honoured (enters DROP at 0x9)
        v(1, 1, 30'h20,      0, 30'h0,  0, 32'h0,         1, 30'h9,        1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hBAD0_0009, 1, 30'h9,        1, 0, 30'h0,        32'h0);
        // stall three cycles at 0x20 with BusRdy high
`ifdef IF_SKID_BUF_EN
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0020, 1, 30'h20,       0, 0, 30'h0,        32'h0);
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0021, 0, 30'h21,       0, 0, 30'h0,        32'h0);
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0021, 0, 30'h21,       0, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0021, 0, 30'h21,       0, 1, 30'h20,       32'hD000_0020);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0021, 1, 30'h21,       0, 1, 30'h21,       32'hD000_0021);
`else
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0020, 1, 30'h20,       0, 0, 30'h0,        32'h0);
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0020, 1, 30'h20,       0, 0, 30'h0,        32'h0);
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0020, 1, 30'h20,       0, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0020, 1, 30'h20,       0, 1, 30'h20,       32'hD000_0020);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0021, 1, 30'h21,       0, 1, 30'h21,       32'hD000_0021);
`endif
        // PC wrap from all-ones
        v(0, 1, 30'h3FFFFFFF, 0, 30'h0, 1, 32'h5555_AAAA, 1, 30'h22,       0, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hDFFF_FFFF, 1, 30'h3FFFFFFF, 0, 1, 30'h3FFFFFFF, 32'hDFFF_FFFF);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0000, 1, 30'h0,        0, 1, 30'h0,        32'hD000_0000);
        // branch under stall is ignored; IF/ID holds
        v(1, 0, 30'h0,       1, 30'h50, 0, 32'h0,         1, 30'h1,        1, 1, 30'h0,        32'hD000_0000);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0001, 1, 30'h1,        0, 1, 30'h1,        32'hD000_0001);
        // flush arriving one cycle after a stalled word returned
`ifdef IF_SKID_BUF_EN
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0002, 1, 30'h2,        0, 1, 30'h1,        32'hD000_0001);
        v(1, 1, 30'h60,      0, 30'h0,  0, 32'h0,         0, 30'h3,        0, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0060, 1, 30'h60,       0, 1, 30'h60,       32'hD000_0060);
`else
        v(1, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0002, 1, 30'h2,        0, 1, 30'h1,        32'hD000_0001);
        v(1, 1, 30'h60,      0, 30'h0,  0, 32'h0,         1, 30'h2,        1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hBAD0_0002, 1, 30'h2,        1, 0, 30'h0,        32'h0);
        v(0, 0, 30'h0,       0, 30'h0,  1, 32'hD000_0060, 1, 30'h60,       0, 1, 30'h60,       32'hD000_0060);
`endif

        // ---------------- reset state ----------------
        reset = 1'b1; Stall = 0; Flush = 0; BrTaken = 0; BusRdy = 0;
        NewPC = '0; BrAddr = '0; BusRdData = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busreq", {31'b0, BusReq}, 32'h0);
        chk("rst_ifen",   {31'b0, IFEn},   32'h0);
        chk("rst_ifpc",   {2'b0, IFPC},    32'h0);
        chk("rst_ifinsn", IFInsn,          32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            Stall = vecs[i].st;  Flush = vecs[i].fl;  NewPC = vecs[i].npc;
            BrTaken = vecs[i].br; BrAddr = vecs[i].ba;
            BusRdy = vecs[i].rdy; BusRdData = vecs[i].d;
            #1;
            chk($sformatf("v%0d_busreq", i), {31'b0, BusReq}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_busaddr", i), {2'b0, BusAddr}, {2'b0, vecs[i].e_addr});
            chk($sformatf("v%0d_busy", i), {31'b0, Busy}, {31'b0, vecs[i].e_busy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ifen", i), {31'b0, IFEn}, {31'b0, vecs[i].e_en});
            if (vecs[i].e_en) begin
                chk($sformatf("v%0d_ifpc", i), {2'b0, IFPC}, {2'b0, vecs[i].e_pc});
                chk($sformatf("v%0d_ifinsn", i), IFInsn, vecs[i].e_insn);
            end
            @(negedge clk);
        end

        // ---------------- reset asserted mid-request ----------------
        Stall = 0; Flush = 0; BrTaken = 0; BusRdy = 0; BusRdData = '0;
        #1;
        chk("mid_busreq_pre", {31'b0, BusReq}, 32'h1);
        chk("mid_busaddr_pre", {2'b0, BusAddr}, 32'h60 + 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_busreq_rst", {31'b0, BusReq}, 32'h0);
        chk("mid_busy_rst",   {31'b0, Busy},   32'h0);
        chk("mid_ifen_rst",   {31'b0, IFEn},   32'h0);
        chk("mid_ifpc_rst",   {2'b0, IFPC},    32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_busreq_rel", {31'b0, BusReq}, 32'h1);
        chk("mid_busaddr_rel", {2'b0, BusAddr}, 32'h100);
        BusRdy = 1'b1; BusRdData = 32'hCAFE_0100;
        @(posedge clk);
        #1;
        chk("mid_ifen_first", {31'b0, IFEn}, 32'h1);
        chk("mid_ifpc_first", {2'b0, IFPC},  32'h100);
        chk("mid_ifinsn_first", IFInsn,      32'hCAFE_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
